// File: rtl/ctrl_pkg.sv
// Shared encodings for the instruction register, decoder and control FSM.
package ctrl_pkg;

    // Control FSM states
    typedef enum logic [2:0] {
        StWait   = 3'd0,
        StDecode = 3'd1,
        StWimm   = 3'd2,
        StGetA   = 3'd3,
        StGetB   = 3'd4,
        StAlu    = 3'd5,
        StWreg   = 3'd6
    } state_e;

    // Opcode field IR[15:13]
    localparam logic [2:0] OpcMov = 3'b110;
    localparam logic [2:0] OpcAlu = 3'b101;

    // Op field IR[12:11]; meaning depends on the opcode
    localparam logic [1:0] OpMovReg = 2'b00;
    localparam logic [1:0] OpMovImm = 2'b10;
    localparam logic [1:0] OpAdd    = 2'b00;
    localparam logic [1:0] OpCmp    = 2'b01;
    localparam logic [1:0] OpAnd    = 2'b10;
    localparam logic [1:0] OpMvn    = 2'b11;

    // One-hot write-back source select
    localparam logic [3:0] VselC     = 4'b0001;
    localparam logic [3:0] VselPc    = 4'b0010;
    localparam logic [3:0] VselImm8  = 4'b0100;
    localparam logic [3:0] VselMdata = 4'b1000;

    // Register-number source select
    typedef enum logic [1:0] {
        NselRn = 2'd0,
        NselRm = 2'd1,
        NselRd = 2'd2
    } nsel_e;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction field decoder: register-number mux and immediates.
module instr_dec
    import ctrl_pkg::*;
(
    input  logic [15:0] ir,
    input  nsel_e       nsel,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    logic [2:0] reg_num;

    // Select Rn, Rm or Rd as the register-file address
    always_comb begin
        reg_num = ir[10:8];
        unique case (nsel)
            NselRn:  reg_num = ir[10:8];
            NselRm:  reg_num = ir[2:0];
            NselRd:  reg_num = ir[7:5];
            default: reg_num = ir[10:8];
        endcase
    end

    // Fixed field extraction; ALU op only meaningful for ALU-class opcodes
    always_comb begin
        opcode   = ir[15:13];
        op       = ir[12:11];
        readnum  = reg_num;
        writenum = reg_num;
        shift    = ir[4:3];
        ALUop    = (ir[15:13] == OpcAlu) ? ir[12:11] : 2'b00;
        sximm5   = sext5(ir[4:0]);
        sximm8   = sext8(ir[7:0]);
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction register and multi-cycle control FSM driving the datapath.
module cpu_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [3:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    state_e      state_q;
    logic [15:0] ir_q;
    nsel_e       nsel;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic        is_mov_reg;
    logic        is_cmp;

    instr_dec u_instr_dec (
        .ir       (ir_q),
        .nsel     (nsel),
        .opcode   (opcode),
        .op       (op),
        .readnum  (readnum),
        .writenum (writenum),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm5   (sximm5),
        .sximm8   (sximm8)
    );

    assign is_mov_reg = (opcode == OpcMov) && (op == OpMovReg);
    assign is_cmp     = (opcode == OpcAlu) && (op == OpCmp);

    // State sequencing and IR capture; IR only loads while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWait;
            ir_q    <= '0;
        end else begin
            unique case (state_q)
                StWait: begin
                    if (load) ir_q <= in;
                    if (s) state_q <= StDecode;
                end
                StDecode: begin
                    unique case ({opcode, op})
                        {OpcMov, OpMovImm}: state_q <= StWimm;
                        {OpcMov, OpMovReg},
                        {OpcAlu, OpMvn}:    state_q <= StGetB;
                        {OpcAlu, OpAdd},
                        {OpcAlu, OpCmp},
                        {OpcAlu, OpAnd}:    state_q <= StGetA;
                        default:            state_q <= StWait;
                    endcase
                end
                StWimm:  state_q <= StWait;
                StGetA:  state_q <= StGetB;
                StGetB:  state_q <= StAlu;
                StAlu:   state_q <= is_cmp ? StWait : StWreg;
                StWreg:  state_q <= StWait;
                default: state_q <= StWait;
            endcase
        end
    end

    // Moore outputs decoded from the current state and IR
    always_comb begin
        w     = 1'b0;
        nsel  = NselRn;
        vsel  = VselC;
        loada = 1'b0;
        loadb = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        write = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        unique case (state_q)
            StWait: w = 1'b1;
            StDecode: ;
            StWimm: begin
                vsel  = VselImm8;
                write = 1'b1;
            end
            StGetA: loada = 1'b1;
            StGetB: begin
                nsel  = NselRm;
                loadb = 1'b1;
            end
            StAlu: begin
                // MOV reg passes B through the ALU with a zero A operand
                asel  = is_mov_reg;
                loadc = !is_cmp;
                loads = is_cmp;
            end
            StWreg: begin
                nsel  = NselRd;
                write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: directed scenarios plus randomized instructions.
module tb_cpu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s = 1'b0;
    logic        load = 1'b0;
    logic [15:0] in = 16'h0000;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [3:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        write;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    int checks = 0;
    int errors = 0;

    cpu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .load     (load),
        .in       (in),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .write    (write),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    always #5 clk = ~clk;

    // Expected observable behaviour for one cycle
    typedef struct packed {
        logic       w;
        logic [2:0] rnum;
        logic       la;
        logic       lb;
        logic       lc;
        logic       ls;
        logic       wr;
        logic       as;
        logic [3:0] vsel;
    } exp_t;

    exp_t plan[$];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t step(input logic ew, input logic [2:0] rnum, input logic la,
                                  input logic lb, input logic lc, input logic ls,
                                  input logic wr, input logic as, input logic [3:0] vs);
        exp_t e;
        e.w = ew; e.rnum = rnum; e.la = la; e.lb = lb; e.lc = lc;
        e.ls = ls; e.wr = wr; e.as = as; e.vsel = vs;
        return e;
    endfunction

    // Reference: the list of micro-steps an instruction performs, ending back at idle
    function automatic void make_plan(input logic [15:0] ir);
        logic [2:0] rn = ir[10:8];
        logic [2:0] rd = ir[7:5];
        logic [2:0] rm = ir[2:0];
        exp_t rd_a  = step(0, rn, 1, 0, 0, 0, 0, 0, 4'b0001);
        exp_t rd_b  = step(0, rm, 0, 1, 0, 0, 0, 0, 4'b0001);
        exp_t calc  = step(0, rn, 0, 0, 1, 0, 0, 0, 4'b0001);
        exp_t wback = step(0, rd, 0, 0, 0, 0, 1, 0, 4'b0001);
        plan.delete();
        plan.push_back(step(0, rn, 0, 0, 0, 0, 0, 0, 4'b0001));
        case (ir[15:11])
            5'b11010: plan.push_back(step(0, rn, 0, 0, 0, 0, 1, 0, 4'b0100));
            5'b11000: begin
                plan.push_back(rd_b);
                plan.push_back(step(0, rn, 0, 0, 1, 0, 0, 1, 4'b0001));
                plan.push_back(wback);
            end
            5'b10100, 5'b10110: begin
                plan.push_back(rd_a);
                plan.push_back(rd_b);
                plan.push_back(calc);
                plan.push_back(wback);
            end
            5'b10111: begin
                plan.push_back(rd_b);
                plan.push_back(calc);
                plan.push_back(wback);
            end
            5'b10101: begin
                plan.push_back(rd_a);
                plan.push_back(rd_b);
                plan.push_back(step(0, rn, 0, 0, 0, 1, 0, 0, 4'b0001));
            end
            default: ;
        endcase
        plan.push_back(step(1, rn, 0, 0, 0, 0, 0, 0, 4'b0001));
    endfunction

    task automatic check_cycle(input exp_t e, input logic [15:0] ir, input string tag);
        int v8 = int'(ir[7:0]);
        int v5 = int'(ir[4:0]);
        if (v8 >= 128) v8 = v8 - 256;
        if (v5 >= 16) v5 = v5 - 32;
        chk({tag, ".w"}, 16'(w), 16'(e.w));
        chk({tag, ".readnum"}, 16'(readnum), 16'(e.rnum));
        chk({tag, ".writenum"}, 16'(writenum), 16'(e.rnum));
        chk({tag, ".loada"}, 16'(loada), 16'(e.la));
        chk({tag, ".loadb"}, 16'(loadb), 16'(e.lb));
        chk({tag, ".loadc"}, 16'(loadc), 16'(e.lc));
        chk({tag, ".loads"}, 16'(loads), 16'(e.ls));
        chk({tag, ".write"}, 16'(write), 16'(e.wr));
        chk({tag, ".asel"}, 16'(asel), 16'(e.as));
        chk({tag, ".bsel"}, 16'(bsel), 16'h0);
        chk({tag, ".vsel"}, 16'(vsel), 16'(e.vsel));
        chk({tag, ".shift"}, 16'(shift), 16'(ir[4:3]));
        chk({tag, ".ALUop"}, 16'(ALUop), (ir[15:13] == 3'b101) ? 16'(ir[12:11]) : 16'h0);
        chk({tag, ".sximm8"}, sximm8, 16'(v8));
        chk({tag, ".sximm5"}, sximm5, 16'(v5));
    endtask

    // Issue one instruction from idle and follow it to completion against the model
    task automatic run_model(input logic [15:0] ir, input bit junk, input string tag);
        in = ir;
        load = 1'b1;
        s = 1'b1;
        make_plan(ir);
        tick();
        load = 1'b0;
        s = 1'b0;
        for (int i = 0; i < plan.size(); i++) begin
            check_cycle(plan[i], ir, $sformatf("%s[%0d]", tag, i));
            if (i < plan.size() - 1) begin
                if (junk) begin
                    s = 1'($urandom);
                    load = 1'($urandom);
                    in = 16'($urandom);
                end
                tick();
            end
        end
        s = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        logic [4:0] kinds [7];
        logic [15:0] ir;
        kinds = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b00000};

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst.w", 16'(w), 16'h1);
        chk("rst.strobes", 16'({loada, loadb, loadc, loads, write, asel, bsel}), 16'h0);
        chk("rst.vsel", 16'(vsel), 16'h1);
        chk("rst.readnum", 16'(readnum), 16'h0);
        chk("rst.writenum", 16'(writenum), 16'h0);
        chk("rst.sximm8", sximm8, 16'h0);
        chk("rst.sximm5", sximm5, 16'h0);
        chk("rst.shift_aluop", 16'({shift, ALUop}), 16'h0);

        // MOV R0,#7
        in = 16'hD007; load = 1'b1; s = 1'b1;
        tick();
        load = 1'b0; s = 1'b0;
        chk("movi.decode_w", 16'(w), 16'h0);
        tick();
        chk("movi.write", 16'(write), 16'h1);
        chk("movi.writenum", 16'(writenum), 16'h0);
        chk("movi.vsel", 16'(vsel), 16'h4);
        chk("movi.sximm8", sximm8, 16'h0007);
        tick();
        chk("movi.done_w", 16'(w), 16'h1);

        // MOV R1,#-2, CMP R1,R0 via the model
        run_model(16'hD1FE, 1'b0, "movneg");
        run_model(16'hA900, 1'b0, "cmp");

        // ADD R2,R1,R0,LSL#1
        in = 16'hA148; load = 1'b1; s = 1'b1;
        tick();
        load = 1'b0; s = 1'b0;
        tick();
        chk("add.geta_readnum", 16'(readnum), 16'h1);
        chk("add.geta_loada", 16'(loada), 16'h1);
        tick();
        chk("add.getb_readnum", 16'(readnum), 16'h0);
        chk("add.getb_loadb", 16'(loadb), 16'h1);
        chk("add.getb_shift", 16'(shift), 16'h1);
        tick();
        chk("add.alu_aluop", 16'(ALUop), 16'h0);
        chk("add.alu_loadc", 16'(loadc), 16'h1);
        tick();
        chk("add.wreg_writenum", 16'(writenum), 16'h2);
        chk("add.wreg_write", 16'(write), 16'h1);
        chk("add.wreg_vsel", 16'(vsel), 16'h1);
        tick();
        chk("add.done_w", 16'(w), 16'h1);

        // Reset during GETB of an ADD
        in = 16'hA148; load = 1'b1; s = 1'b1;
        tick();
        load = 1'b0; s = 1'b0;
        tick();
        tick();
        chk("rstmid.getb_loadb", 16'(loadb), 16'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid.w", 16'(w), 16'h1);
        chk("rstmid.write", 16'(write), 16'h0);
        chk("rstmid.loads", 16'(loads), 16'h0);
        chk("rstmid.ir_cleared", sximm8, 16'h0);
        s = 1'b1;
        tick();
        s = 1'b0;
        chk("rstmid.decode_w", 16'(w), 16'h0);
        chk("rstmid.decode_strobes", 16'({loada, loadb, loadc, loads, write}), 16'h0);
        tick();
        chk("rstmid.unsup_w", 16'(w), 16'h1);
        chk("rstmid.unsup_write", 16'(write), 16'h0);

        // ADD with load/s pulsed mid-instruction; s then held through completion
        in = 16'hA148; load = 1'b1; s = 1'b1;
        tick();
        load = 1'b0; s = 1'b0;
        tick();
        chk("ign.geta_loada", 16'(loada), 16'h1);
        in = 16'hD0FF; load = 1'b1; s = 1'b1;
        tick();
        load = 1'b0;
        chk("ign.getb_readnum", 16'(readnum), 16'h0);
        chk("ign.getb_sximm8", sximm8, 16'h0048);
        tick();
        chk("ign.alu_loadc", 16'(loadc), 16'h1);
        tick();
        chk("ign.wreg_writenum", 16'(writenum), 16'h2);
        chk("ign.wreg_write", 16'(write), 16'h1);
        tick();
        chk("ign.wait_w", 16'(w), 16'h1);
        chk("ign.wait_sximm8", sximm8, 16'h0048);
        tick();
        s = 1'b0;
        chk("ign.restart_w", 16'(w), 16'h0);
        chk("ign.restart_readnum", 16'(readnum), 16'h1);
        for (int i = 0; i < 5; i++) tick();
        chk("ign.restart_done_w", 16'(w), 16'h1);

        // Randomized instructions with junk on s/load/in while busy
        for (int n = 0; n < 60; n++) begin
            ir = 16'($urandom);
            if ($urandom_range(0, 9) != 0) ir[15:11] = kinds[$urandom_range(0, 6)];
            run_model(ir, 1'b1, $sformatf("rnd%0d_%h", n, ir));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
